// File: rtl/skinny_sbox_layer_seq.sv
// Serial sequencer for one masked SKINNY-64 S-box layer (3 shares, external pipelined S-box).
// Optional randomness-valid monitor enabled by defining SEQ_RND_CHECK_EN.
module skinny_sbox_layer_seq #(
    parameter int LATENCY = 4,
    parameter int CELLS   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*CELLS-1:0]   state_in1,
    input  logic [4*CELLS-1:0]   state_in2,
    input  logic [4*CELLS-1:0]   state_in3,
    input  logic [31:0]          rnd_in,
    output logic [3:0]           sb_in1,
    output logic [3:0]           sb_in2,
    output logic [3:0]           sb_in3,
    output logic [23:0]          sb_r,
    output logic [7:0]           sb_rc,
    input  logic [3:0]           sb_out1,
    input  logic [3:0]           sb_out2,
    input  logic [3:0]           sb_out3,
    output logic [4*CELLS-1:0]   state_out1,
    output logic [4*CELLS-1:0]   state_out2,
    output logic [4*CELLS-1:0]   state_out3,
`ifdef SEQ_RND_CHECK_EN
    input  logic                 rnd_valid,
    output logic                 rnd_err,
`endif
    output logic                 busy,
    output logic                 done
);

    localparam int W     = 4 * CELLS;
    localparam int TOTAL = CELLS + LATENCY;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam logic [CW-1:0] K_LAST = CW'(TOTAL - 1);
    localparam logic [CW-1:0] K_FEED = CW'(CELLS);
    localparam logic [CW-1:0] K_COL  = CW'(LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE_ST
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    feed1, feed2, feed3;
    logic [W-1:0]    col1, col2, col3;
    logic [W-1:0]    col1_nxt, col2_nxt, col3_nxt;

    // Feed registers drain to zero, so the S-box sees zeros once all cells are sent.
    assign sb_in1 = feed1[W-1 -: 4];
    assign sb_in2 = feed2[W-1 -: 4];
    assign sb_in3 = feed3[W-1 -: 4];

    assign sb_r  = rnd_in[23:0];
    assign sb_rc = rnd_in[31:24];

    assign col1_nxt = {col1[W-5:0], sb_out1};
    assign col2_nxt = {col2[W-5:0], sb_out2};
    assign col3_nxt = {col3[W-5:0], sb_out3};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            feed1      <= '0;
            feed2      <= '0;
            feed3      <= '0;
            col1       <= '0;
            col2       <= '0;
            col3       <= '0;
            state_out1 <= '0;
            state_out2 <= '0;
            state_out3 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        feed1 <= state_in1;
                        feed2 <= state_in2;
                        feed3 <= state_in3;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (cnt < K_FEED) begin
                        feed1 <= feed1 << 4;
                        feed2 <= feed2 << 4;
                        feed3 <= feed3 << 4;
                    end
                    if (cnt >= K_COL) begin
                        col1 <= col1_nxt;
                        col2 <= col2_nxt;
                        col3 <= col3_nxt;
                    end
                    // Last capture lands straight in state_out so it is valid with done.
                    if (cnt == K_LAST) begin
                        state_out1 <= col1_nxt;
                        state_out2 <= col2_nxt;
                        state_out3 <= col3_nxt;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE_ST;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE_ST: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SEQ_RND_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rnd_err <= 1'b0;
        end else if (state == IDLE && start) begin
            rnd_err <= 1'b0;
        end else if (busy && !rnd_valid) begin
            rnd_err <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/skinny_sbox_layer_seq.md
Name: skinny_sbox_layer_seq

Overview:
- Serial sequencer for one full S-box layer of masked SKINNY-64, 3 shares, second-order.
- Loads a 3-share 64-bit state and streams its 16 cells, one nibble per cycle, into the external 4-stage pipelined masked S-box.
- Supplies the S-box's fresh randomness (r, rc) each cycle.
- Collects the shared outputs in cell order and presents the substituted 3-share state to the linear layer downstream.

Parameters:
- LATENCY, 4, S-box pipeline depth in cycles, from cell presented to shares valid at S-box output.
- CELLS, 16, number of 4-bit cells per state.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  load state_in* and begin a layer; sampled only in IDLE.
- state_in1  in  64  share 1 of input state; cell 0 = bits [63:60].
- state_in2  in  64  share 2.
- state_in3  in  64  share 3.
- rnd_in  in  32  fresh randomness; [23:0] -> sb_r, [31:24] -> sb_rc.
- sb_in1  out  4  cell share 1 to S-box.
- sb_in2  out  4  cell share 2 to S-box.
- sb_in3  out  4  cell share 3 to S-box.
- sb_r  out  24  S-box gadget randomness (stage-1 [11:0], stage-2 [23:12]).
- sb_rc  out  8  S-box output remask value.
- sb_out1  in  4  S-box output share 1.
- sb_out2  in  4  S-box output share 2.
- sb_out3  in  4  S-box output share 3.
- state_out1  out  64  substituted share 1; cell 0 = bits [63:60].
- state_out2  out  64  substituted share 2.
- state_out3  out  64  substituted share 3.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  single-cycle pulse; state_out* valid from this cycle until the next accepted start.

Behaviour:
- Reset: FSM = IDLE; cycle counter = 0; busy = 0; done = 0; state_out1..3 = 0; sb_in* = 0.
- FSM states:
  - IDLE: start=1 loads three 64-bit feed shift registers, clears the counter, and moves to RUN.
  - RUN: 16+LATENCY cycles, counter k = 0..CELLS+LATENCY-1.
  - DONE: 1 cycle, pulses done, returns to IDLE.
- Feed, RUN cycles k < CELLS: sb_in* = top nibble of the feed regs (cell k); feed regs shift left by 4 each cycle. For k >= CELLS, sb_in* = 0.
- Collect, RUN cycles k >= LATENCY: sb_out* sampled at the edge ending cycle k and shifted into the collect regs from the LSB, 4 bits per cycle. After 16 captures, cell 0 sits at [63:60].
- state_out* update only in the DONE cycle, from the collect regs; held otherwise.
- sb_r = rnd_in[23:0] and sb_rc = rnd_in[31:24] every cycle, combinationally, in all states. The randomness source delivers a fresh value every clk; there is no stall path.
- Total latency: start accepted at edge E0; done high in the cycle after edge E0+CELLS+LATENCY (cycle 21 for defaults).
- start while busy or in DONE: ignored.
- rst mid-RUN: immediate return to IDLE, no done, state_out* cleared. Stale S-box pipeline contents are discarded because collection restarts at k = LATENCY after the next start.
- Shares are never combined inside this block; each share path is a separate register set.

Optional Feature:
- Macro: SEQ_RND_CHECK_EN.
- Defined:
  - Adds input rnd_valid (1 bit) and output rnd_err (1 bit).
  - rnd_err sets sticky in the cycle after any busy cycle with rnd_valid = 0.
  - rnd_err clears on rst or on an accepted start.
  - Datapath and timing are unchanged.
- Undefined: both ports are absent and no check logic is built.

Test Plan:
- Unmasked sanity: state_in1 = 0x0123456789ABCDEF, shares 2 and 3 = 0, rnd_in = 0, start -> done at cycle 21; out1^out2^out3 = 0xC6901A2B385D4E7F.
- Random masking: same plaintext, state_in2/3 random, rnd_in random each cycle -> XOR of the three output shares = 0xC6901A2B385D4E7F; individual shares differ from the previous run.
- Zero state with random shares -> recombined output = 0xCCCCCCCCCCCCCCCC.
- start pulsed again at RUN k = 5 -> ignored; result and done timing identical to the single-start case.
- rst asserted at RUN k = 10, then restart with 0x0123456789ABCDEF -> first done shows no stale cells; output = 0xC6901A2B385D4E7F.
- SEQ_RND_CHECK_EN: rnd_valid = 0 at k = 3 -> rnd_err = 1 from k = 4 through done; next start clears rnd_err to 0.
